// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Purpose  : Brings a PLL out of reset and qualifies its lock indication
//             before releasing downstream logic. Sequence: pulse PLL reset,
//             wait for lock (with timeout and bounded retries), require a run
//             of consecutive lock cycles, then release. Lock loss while running
//             restarts the sequence; exhausted retries park in a sticky fail
//             state until rst or relock_req.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    refclk      in   reference clock, clocks all logic
//    rst         in   asynchronous active-high reset
//    pll_locked  in   raw PLL lock, asynchronous to refclk
//    relock_req  in   single-cycle request to restart the PLL sequence
//    pll_rst     out  active-high reset to the PLL
//    sys_rst     out  active-high reset for logic on PLL output clocks
//    ready       out  PLL locked and stable
//    fail        out  retries exhausted (sticky)
//    loss_evt    out  one-cycle pulse on loss of lock while running
//    retry_cnt   out  retries used in current sequence, saturating at 3
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 50,
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic       loss_evt,
    output logic [1:0] retry_cnt
);

    // Counter widths: each counter only ever holds 0 .. PARAM-1.
    localparam int C_PULSE_W  = (RST_PULSE_CYC    > 1) ? $clog2(RST_PULSE_CYC)    : 1;
    localparam int C_STABLE_W = (LOCK_STABLE_CYC  > 1) ? $clog2(LOCK_STABLE_CYC)  : 1;
    localparam int C_WAIT_W   = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;

    localparam logic [C_PULSE_W-1:0]  C_PULSE_LAST  = C_PULSE_W'(RST_PULSE_CYC - 1);
    localparam logic [C_STABLE_W-1:0] C_STABLE_LAST = C_STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [C_WAIT_W-1:0]   C_WAIT_LAST   = C_WAIT_W'(LOCK_TIMEOUT_CYC - 1);

    // retry_cnt is only two bits wide, so the usable retry limit caps at 3.
    localparam logic [1:0] C_RETRY_LIMIT = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t                state_q,      state_d;
    logic [C_PULSE_W-1:0]  pulse_cnt_q,  pulse_cnt_d;
    logic [C_WAIT_W-1:0]   wait_cnt_q,   wait_cnt_d;
    logic [C_STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [1:0]            retry_cnt_q,  retry_cnt_d;
    logic                  pll_rst_q,    pll_rst_d;
    logic                  sys_rst_q,    sys_rst_d;
    logic                  ready_q,      ready_d;
    logic                  fail_q,       fail_d;
    logic                  loss_evt_q,   loss_evt_d;

    logic [1:0]            sync_q;
    logic                  locked_s;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous lock indication.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // ------------------------------------------------------------------
    // State and counter registers.
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET_PLL;
            pulse_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            stable_cnt_q <= '0;
            retry_cnt_q  <= 2'd0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            loss_evt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            loss_evt_q   <= loss_evt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic. Outputs are decoded from the next
    // state so they are already correct on the edge that enters it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        stable_cnt_d = stable_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        loss_evt_d   = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (pulse_cnt_q == C_PULSE_LAST) begin
                    state_d    = S_WAIT_LOCK;
                    wait_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + C_PULSE_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = '0;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    if (retry_cnt_q < C_RETRY_LIMIT) begin
                        retry_cnt_d = retry_cnt_q + 2'd1;
                        state_d     = S_RESET_PLL;
                        pulse_cnt_d = '0;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + C_WAIT_W'(1);
                end
            end

            S_STABLE: begin
                if (!locked_s) begin
                    // Any dropout restarts qualification; the timeout window
                    // also starts over since the PLL did achieve lock.
                    state_d    = S_WAIT_LOCK;
                    wait_cnt_d = '0;
                end else if (stable_cnt_q == C_STABLE_LAST) begin
                    state_d     = S_RUN;
                    retry_cnt_d = 2'd0;
                end else begin
                    stable_cnt_d = stable_cnt_q + C_STABLE_W'(1);
                end
            end

            S_RUN: begin
                if (!locked_s) begin
                    loss_evt_d  = 1'b1;
                    state_d     = S_RESET_PLL;
                    pulse_cnt_d = '0;
                end
            end

            S_FAIL: begin
                state_d = S_FAIL;
            end

            default: begin
                state_d     = S_RESET_PLL;
                pulse_cnt_d = '0;
            end
        endcase

        // A relock request overrides every other transition but leaves a
        // coincident loss_evt pulse intact.
        if (relock_req) begin
            state_d     = S_RESET_PLL;
            pulse_cnt_d = '0;
            retry_cnt_d = 2'd0;
        end

        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign loss_evt  = loss_evt_q;
    assign retry_cnt = retry_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_sequencer
//  Purpose  : Self-checking bench for pll_lock_sequencer. A phase/countdown
//             model predicts every output each cycle; directed scenarios pin
//             literal edge-numbered expectations; a randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int P_PULSE   = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TIMEOUT = 20;
    localparam int P_RETRY   = 2;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       loss_evt;
    logic [1:0] retry_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int ecount;

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (P_PULSE),
        .LOCK_STABLE_CYC  (P_STABLE),
        .LOCK_TIMEOUT_CYC (P_TIMEOUT),
        .MAX_RETRIES      (P_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .loss_evt   (loss_evt),
        .retry_cnt  (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Edge number since the last reset release (edge 1 = first edge after rst falls).
    always @(posedge refclk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, ecount, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase + countdown of cycles remaining in it.
    // ------------------------------------------------------------------
    localparam int PH_PULSE = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
    int       m_ph;
    int       m_left;
    int       m_retries;
    bit       m_loss;
    bit [1:0] m_hist;   // last two sampled pll_locked values, [1] = older

    task automatic m_reset();
        m_ph      = PH_PULSE;
        m_left    = P_PULSE;
        m_retries = 0;
        m_loss    = 1'b0;
        m_hist    = 2'b00;
    endtask

    task automatic m_step();
        bit ls;
        ls     = m_hist[1];
        m_loss = 1'b0;
        case (m_ph)
            PH_PULSE: begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_ph = PH_WAIT; m_left = P_TIMEOUT; end
            end
            PH_WAIT: begin
                if (ls) begin
                    m_ph = PH_STABLE; m_left = P_STABLE;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_retries < P_RETRY) begin
                            m_retries = m_retries + 1; m_ph = PH_PULSE; m_left = P_PULSE;
                        end else begin
                            m_ph = PH_FAIL;
                        end
                    end
                end
            end
            PH_STABLE: begin
                if (!ls) begin
                    m_ph = PH_WAIT; m_left = P_TIMEOUT;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_ph = PH_RUN; m_retries = 0; end
                end
            end
            PH_RUN: begin
                if (!ls) begin m_loss = 1'b1; m_ph = PH_PULSE; m_left = P_PULSE; end
            end
            default: ;
        endcase
        if (relock_req) begin
            m_ph = PH_PULSE; m_left = P_PULSE; m_retries = 0;
        end
        m_hist = {m_hist[0], pll_locked};
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge refclk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge refclk);
            if (rst === 1'b0) begin
                chk("pll_rst",   pll_rst,   (m_ph == PH_PULSE || m_ph == PH_FAIL) ? 1 : 0);
                chk("sys_rst",   sys_rst,   (m_ph != PH_RUN) ? 1 : 0);
                chk("ready",     ready,     (m_ph == PH_RUN) ? 1 : 0);
                chk("fail",      fail,      (m_ph == PH_FAIL) ? 1 : 0);
                chk("loss_evt",  loss_evt,  m_loss ? 1 : 0);
                chk("retry_cnt", retry_cnt, (m_retries > 3) ? 3 : m_retries);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic at_edge(input int n);
        int guard;
        guard = 0;
        while (ecount < n) begin
            @(negedge refclk);
            guard = guard + 1;
            if (guard > 20000) begin
                $display("FAIL at_edge timeout: edge %0d never reached, at %0d", n, ecount);
                $fatal(1);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge refclk);
        #1 rst = 1'b1;
        repeat (3) @(negedge refclk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".pll_rst"},   pll_rst,   1);
        chk({tag, ".sys_rst"},   sys_rst,   1);
        chk({tag, ".ready"},     ready,     0);
        chk({tag, ".fail"},      fail,      0);
        chk({tag, ".loss_evt"},  loss_evt,  0);
        chk({tag, ".retry_cnt"}, retry_cnt, 0);
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        relock_req = 1'b0;
        repeat (2) @(negedge refclk);
        #1 chk_reset_values("por");

        // Nominal lock
        apply_reset();
        at_edge(3);  chk("nom.pll_rst_e3",  pll_rst, 1);
        at_edge(4);  chk("nom.pll_rst_e4",  pll_rst, 0);
                     chk("nom.sys_rst_e4",  sys_rst, 1);
        at_edge(12); chk("nom.ready_e12",   ready,   0);
        at_edge(13); chk("nom.ready_e13",   ready,   1);
                     chk("nom.sys_rst_e13", sys_rst, 0);
                     chk("nom.retry_e13",   retry_cnt, 0);

        // Timeout / fail, then recovery via relock_req
        pll_locked = 1'b0;
        apply_reset();
        at_edge(23);  chk("to.retry_e23", retry_cnt, 0);
        at_edge(24);  chk("to.retry_e24", retry_cnt, 1);
                      chk("to.pll_rst_e24", pll_rst, 1);
        at_edge(48);  chk("to.retry_e48", retry_cnt, 2);
        at_edge(71);  chk("to.fail_e71",  fail, 0);
        at_edge(72);  chk("to.fail_e72",  fail, 1);
                      chk("to.pll_rst_e72", pll_rst, 1);
        at_edge(150); chk("to.fail_e150", fail, 1);
        pll_locked = 1'b1;
        at_edge(153); relock_req = 1'b1;
        at_edge(154); relock_req = 1'b0;
                      chk("rec.fail_e154",  fail, 0);
                      chk("rec.retry_e154", retry_cnt, 0);
        at_edge(166); chk("rec.ready_e166", ready, 0);
        at_edge(167); chk("rec.ready_e167", ready, 1);

        // Glitch in STABLE, then loss in RUN, then loss coinciding with relock
        apply_reset();
        at_edge(8);  pll_locked = 1'b0;
        at_edge(11); pll_locked = 1'b1;
        at_edge(13); chk("gl.ready_e13", ready, 0);
        at_edge(21); chk("gl.ready_e21", ready, 0);
        at_edge(22); chk("gl.ready_e22", ready, 1);
                     chk("gl.retry_e22", retry_cnt, 0);
        at_edge(25); pll_locked = 1'b0;
        at_edge(27); chk("loss.ready_e27", ready, 1);
                     chk("loss.evt_e27",   loss_evt, 0);
        at_edge(28); chk("loss.evt_e28",   loss_evt, 1);
                     chk("loss.ready_e28", ready, 0);
                     chk("loss.sysrst_e28", sys_rst, 1);
                     chk("loss.pllrst_e28", pll_rst, 1);
                     pll_locked = 1'b1;
        at_edge(29); chk("loss.evt_e29",   loss_evt, 0);
        at_edge(31); chk("loss.pllrst_e31", pll_rst, 1);
        at_edge(32); chk("loss.pllrst_e32", pll_rst, 0);
        at_edge(40); chk("loss.ready_e40", ready, 0);
        at_edge(41); chk("loss.ready_e41", ready, 1);
        at_edge(44); pll_locked = 1'b0;
        at_edge(46); relock_req = 1'b1;
        at_edge(47); relock_req = 1'b0;
                     chk("lossrl.evt_e47", loss_evt, 1);
                     chk("lossrl.pllrst_e47", pll_rst, 1);
                     pll_locked = 1'b1;

        // Relock mid-pulse restarts the pulse, then async reset mid-STABLE
        apply_reset();
        at_edge(2);  relock_req = 1'b1;
        at_edge(3);  relock_req = 1'b0;
        at_edge(6);  chk("mid.pllrst_e6", pll_rst, 1);
        at_edge(7);  chk("mid.pllrst_e7", pll_rst, 0);
        at_edge(10); rst = 1'b1;
        #1 chk_reset_values("async");
        @(negedge refclk);
        #1 rst = 1'b0;
        at_edge(4);  chk("arst.pllrst_e4", pll_rst, 0);
        at_edge(12); chk("arst.ready_e12", ready, 0);
        at_edge(13); chk("arst.ready_e13", ready, 1);

        // Randomized segments of held lock level with sporadic relock/reset
        for (int seg = 0; seg < 45; seg++) begin
            int len;
            pll_locked = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
            len = (pll_locked == 1'b0 && $urandom_range(0, 3) == 0)
                  ? $urandom_range(1, 5) : $urandom_range(1, 120);
            for (int c = 0; c < len; c++) begin
                @(negedge refclk);
                #1;
                relock_req = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 399) == 0) begin
                    rst = 1'b1;
                    #2 rst = 1'b0;
                end
            end
        end
        relock_req = 1'b0;
        repeat (3) @(negedge refclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
